// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data ports.
// Round-robin on ties; each transfer takes LAT access cycles followed by a one-cycle ack.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int N   = 32,
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [N-1:0]  if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [N-1:0]  d_wdata,
  output logic          d_ack,
  output logic [N-1:0]  d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          busy,
  output logic          grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_cnt;
  logic            r_grant_d;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [N-1:0]    r_wdata;
  logic [N-1:0]    r_if_rdata;
  logic [N-1:0]    r_d_rdata;
  logic            w_any_req;
  logic            w_take_d;
  logic            w_last;

  // On a tie, data wins only if fetch was served last.
  assign w_any_req = if_req | d_req;
  assign w_take_d  = d_req & (~if_req | ~r_grant_d);
  assign w_last    = (r_cnt == 3'(LAT - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_grant_d  <= 1'b1;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_d <= w_take_d;
            r_addr    <= w_take_d ? d_addr : if_addr;
            r_we      <= w_take_d & d_we;
            r_wdata   <= d_wdata;
            r_cnt     <= '0;
          end
        end
        ACCESS: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_grant_d)  r_if_rdata <= mem_rdata;
            else if (!r_we)  r_d_rdata  <= mem_rdata;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and data come straight from the grant-time registers, so they hold outside ACCESS.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == ACCESS) && r_we && (r_cnt == 3'd0);
  assign if_ack    = (r_state == DONE) && !r_grant_d;
  assign d_ack     = (r_state == DONE) &&  r_grant_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);
  assign grant_d   = r_grant_d;

endmodule
